// File: rtl/mem_resp_pipe_pkg.sv
// Shared constants for the fixed-latency memory response pipeline.
// Default geometry: 64 KiB byte-addressed, 16-bit words, 4-cycle read latency.
package mem_resp_pipe_pkg;

    localparam int unsigned MEM_LATENCY    = 4;
    localparam int unsigned MEM_ADDR_W     = 16;
    localparam int unsigned MEM_DATA_W     = 16;
    localparam int unsigned MEM_WORDS_LOG2 = 15;

endpackage : mem_resp_pipe_pkg

// File: rtl/mem_lat_stage.sv
// One read-return pipeline stage holding {valid, data}.
// The asynchronous clear discards whatever read this stage was carrying.
module mem_lat_stage #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : mem_lat_stage

// File: rtl/mem_resp_pipe.sv
// Word-addressed storage with a fixed-latency, fully pipelined read return path.
// Read data is sampled at issue, so later writes never affect an in-flight return.
module mem_resp_pipe
    import mem_resp_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned DATA_W     = MEM_DATA_W,
    parameter int unsigned WORDS_LOG2 = MEM_WORDS_LOG2,
    parameter int unsigned LATENCY    = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
);

    localparam int unsigned Words = 2 ** WORDS_LOG2;

    logic [DATA_W-1:0]     mem_q [Words];
    logic [WORDS_LOG2-1:0] word_idx;
    logic                  wr_issue;
    logic                  rd_issue;
    logic                  st0_valid_d;
    logic [DATA_W-1:0]     st0_data_d;

    logic [LATENCY-1:0]    stg_valid_in;
    logic [DATA_W-1:0]     stg_data_in [LATENCY];
    logic [LATENCY-1:0]    stg_valid;
    logic [DATA_W-1:0]     stg_data    [LATENCY];

    // Byte address: bit 0 selects a byte lane we never use; bits above the index wrap.
    assign word_idx = addr[WORDS_LOG2:1];

    if (ADDR_W > WORDS_LOG2 + 1) begin : g_addr_hi_unused
        logic unused_addr;
        assign unused_addr = ^{addr[0], addr[ADDR_W-1:WORDS_LOG2+1]};
    end else begin : g_addr_lo_unused
        logic unused_addr;
        assign unused_addr = addr[0];
    end

    always_comb begin
        wr_issue    = enable & wr;
        rd_issue    = enable & ~wr;
        st0_valid_d = rd_issue;
        st0_data_d  = rd_issue ? mem_q[word_idx] : '0;
    end

    // Storage is deliberately not reset; requests during reset are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_issue) begin
            mem_q[word_idx] <= data_in;
        end
    end

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stg_valid_in[i] = st0_valid_d;
            assign stg_data_in[i]  = st0_data_d;
        end else begin : g_tail
            assign stg_valid_in[i] = stg_valid[i-1];
            assign stg_data_in[i]  = stg_data[i-1];
        end

        mem_lat_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (stg_valid_in[i]),
            .data_i  (stg_data_in[i]),
            .valid_o (stg_valid[i]),
            .data_o  (stg_data[i])
        );
    end

    always_comb begin
        data_valid = stg_valid[LATENCY-1];
        data_out   = data_valid ? stg_data[LATENCY-1] : '0;
        busy       = |stg_valid;
    end

endmodule : mem_resp_pipe

// File: tb/tb_mem_resp_pipe.sv
// Directed plus randomized bench for mem_resp_pipe against a queue-based
// model of read returns (issue edge + latency) and an associative-array memory.
module tb_mem_resp_pipe;

    localparam int L = 4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    logic [15:0] mdl [int];
    ret_t        pend [$];
    int          edge_cnt = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    mem_resp_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    // A read issued at edge N is visible in the cycle after edge N+L-1.
    task automatic check_outputs();
        logic        exp_v;
        logic [15:0] exp_d;
        exp_v = (pend.size() > 0) && (pend[0].due == edge_cnt);
        exp_d = exp_v ? pend[0].data : 16'h0000;
        chk("data_valid", {15'd0, data_valid}, {15'd0, exp_v});
        chk("data_out", data_out, exp_d);
        chk("busy", {15'd0, busy}, {15'd0, pend.size() > 0});
        if (exp_v) void'(pend.pop_front());
    endtask

    task automatic tick(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        int   idx;
        ret_t r;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        edge_cnt++;
        idx = int'(a[15:1]);
        if (rst_n && en) begin
            if (w) begin
                mdl[idx] = d;
            end else begin
                r.due  = edge_cnt + L - 1;
                r.data = mdl.exists(idx) ? mdl[idx] : 16'hDEAD;
                pend.push_back(r);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;

        // Reset state, with a request presented that must be ignored.
        @(negedge clk);
        check_outputs();
        tick(1'b1, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b1;

        // Write then read next cycle.
        tick(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        tick(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(L + 2);

        // Back-to-back reads of preloaded words.
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 16'(2 * i), 16'(16'h1000 + i));
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 16'(2 * i), 16'h0000);
        idle(L + 2);

        // Read sampled at issue, unaffected by a following write.
        tick(1'b1, 1'b1, 16'h0020, 16'h1111);
        tick(1'b1, 1'b0, 16'h0020, 16'h0000);
        tick(1'b1, 1'b1, 16'h0020, 16'h2222);
        tick(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(L + 2);

        // Reset mid-flight discards returns and leaves storage intact.
        tick(1'b1, 1'b0, 16'h0000, 16'h0000);
        tick(1'b1, 1'b0, 16'h0002, 16'h0000);
        tick(1'b1, 1'b0, 16'h0004, 16'h0000);
        rst_n = 1'b0;
        #1;
        pend.delete();
        check_outputs();
        tick(1'b1, 1'b1, 16'h0010, 16'h7777);
        rst_n = 1'b1;
        idle(L + 2);
        tick(1'b1, 1'b0, 16'h0010, 16'h0000);
        tick(1'b1, 1'b0, 16'h0004, 16'h0000);
        idle(L + 2);

        // Address aliasing: bit 0 is ignored.
        tick(1'b1, 1'b1, 16'h0002, 16'hA5A5);
        tick(1'b1, 1'b0, 16'h0003, 16'h0000);
        tick(1'b1, 1'b0, 16'h0002, 16'h0000);
        idle(L + 2);

        // Randomized traffic over a fully preloaded window of 64 words.
        for (int i = 0; i < 64; i++) tick(1'b1, 1'b1, 16'(2 * i), 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 4) != 0, ($urandom % 3) == 0,
                 16'(($urandom_range(0, 63) << 1) | ($urandom & 1)), 16'($urandom));
        end
        idle(L + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_resp_pipe
